// File: rtl/drp_responder.sv
// DRP responder standing in for the XADC primitive.
// 128 x 16 register space: 0x00-0x3F measurement (RO), 0x40-0x7F config (RW).
module drp_responder #(
    parameter int LATENCY = 4   // DEN-to-DRDY cycles, legal range 1..15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        den,
    input  logic        dwe,
    input  logic [6:0]  daddr,
    input  logic [15:0] di,
    output logic [15:0] drp_do,
    output logic        drdy,
    input  logic        sample_valid,
    input  logic [5:0]  sample_chan,
    input  logic [11:0] sample_data,
    output logic        proto_err
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;

    logic [15:0] regs [128];

    logic [6:0]  h_addr;
    logic        h_we;
    logic [15:0] h_di;
    logic [15:0] h_rdata;

    logic        accept;
    logic        violate;

    // State and latency counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: accept in IDLE, count down in BUSY, leave on the drdy cycle
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (den) begin
                    state_nxt = BUSY;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Outputs: drdy on the last BUSY cycle; read data only on read acks
    always_comb begin
        accept  = (state == IDLE) && den;
        violate = (state == BUSY) && den;
        drdy    = (state == BUSY) && (cnt == 4'd0);
        drp_do  = (drdy && !h_we) ? h_rdata : 16'h0000;
    end

    // Holding registers; read data is snapshotted on the accepting edge,
    // so a same-edge sample update to that address is not seen by the read
    always_ff @(posedge clk) begin
        if (rst) begin
            h_addr  <= 7'd0;
            h_we    <= 1'b0;
            h_di    <= 16'h0000;
            h_rdata <= 16'h0000;
        end else if (accept) begin
            h_addr  <= daddr;
            h_we    <= dwe;
            h_di    <= di;
            h_rdata <= regs[daddr];
        end
    end

    // Register file: sample updates in any state, config writes commit
    // at the edge closing drdy; writes to the measurement half are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 128; i++) begin
                regs[i] <= 16'h0000;
            end
        end else begin
            if (sample_valid) begin
                regs[{1'b0, sample_chan}] <= {sample_data, 4'b0000};
            end
            if (drdy && h_we && h_addr[6]) begin
                regs[h_addr] <= h_di;
            end
        end
    end

    // Sticky protocol error: any den seen while a transaction is in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err <= 1'b0;
        end else if (violate) begin
            proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_drp_responder.sv
// Directed bench for drp_responder with a DRDY scoreboard.
// Two instances: LATENCY=4 and LATENCY=1.
module tb_drp_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        den;
    logic        den1;
    logic        dwe;
    logic [6:0]  daddr;
    logic [15:0] di;
    logic        sample_valid;
    logic [5:0]  sample_chan;
    logic [11:0] sample_data;

    logic [15:0] do0;
    logic        drdy0;
    logic        perr0;
    logic [15:0] do1;
    logic        drdy1;
    logic        perr1;

    always #5 clk = ~clk;

    drp_responder #(.LATENCY(4)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .den          (den),
        .dwe          (dwe),
        .daddr        (daddr),
        .di           (di),
        .drp_do       (do0),
        .drdy         (drdy0),
        .sample_valid (sample_valid),
        .sample_chan  (sample_chan),
        .sample_data  (sample_data),
        .proto_err    (perr0)
    );

    drp_responder #(.LATENCY(1)) u_dut1 (
        .clk          (clk),
        .rst          (rst),
        .den          (den1),
        .dwe          (dwe),
        .daddr        (daddr),
        .di           (di),
        .drp_do       (do1),
        .drdy         (drdy1),
        .sample_valid (sample_valid),
        .sample_chan  (sample_chan),
        .sample_data  (sample_data),
        .proto_err    (perr1)
    );

    typedef struct {
        int          due;
        logic [15:0] d;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0;
    exp_t e1;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] ex);
        checks++;
        assert (obs === ex) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, ex);
        end
    endtask

    // Scoreboard: every drdy must match the oldest expected entry
    always @(negedge clk) begin
        if (mon_en) begin
            if (drdy0 === 1'b1) begin
                if (q0.size() == 0) begin
                    chk("l4_extra_drdy", 32'd1, 32'd0);
                end else begin
                    e0 = q0.pop_front();
                    chk("l4_drdy_cycle", cyc, e0.due);
                    chk("l4_do", {16'h0, do0}, {16'h0, e0.d});
                end
            end else begin
                chk("l4_drdy_known", {31'h0, drdy0}, 32'd0);
                chk("l4_do_idle", {16'h0, do0}, 32'd0);
            end
            if (drdy1 === 1'b1) begin
                if (q1.size() == 0) begin
                    chk("l1_extra_drdy", 32'd1, 32'd0);
                end else begin
                    e1 = q1.pop_front();
                    chk("l1_drdy_cycle", cyc, e1.due);
                    chk("l1_do", {16'h0, do1}, {16'h0, e1.d});
                end
            end else begin
                chk("l1_drdy_known", {31'h0, drdy1}, 32'd0);
                chk("l1_do_idle", {16'h0, do1}, 32'd0);
            end
        end
    end

    task automatic issue(input bit which, input bit we,
                         input logic [6:0] a, input logic [15:0] d,
                         input logic [15:0] ex);
        dwe   = we;
        daddr = a;
        di    = d;
        if (!which) begin
            den = 1'b1;
            q0.push_back('{cyc + 4, ex});
        end else begin
            den1 = 1'b1;
            q1.push_back('{cyc + 1, ex});
        end
        @(negedge clk);
        den   = 1'b0;
        den1  = 1'b0;
        dwe   = 1'b0;
        daddr = 7'd0;
        di    = 16'h0;
    endtask

    task automatic txn(input bit which, input bit we,
                       input logic [6:0] a, input logic [15:0] d,
                       input logic [15:0] ex);
        issue(which, we, a, d, ex);
        repeat (which ? 1 : 4) @(negedge clk);
    endtask

    task automatic sample(input logic [5:0] ch, input logic [11:0] d);
        sample_valid = 1'b1;
        sample_chan  = ch;
        sample_data  = d;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        den          = 1'b0;
        den1         = 1'b0;
        dwe          = 1'b0;
        daddr        = 7'd0;
        di           = 16'h0;
        sample_valid = 1'b0;
        sample_chan  = 6'd0;
        sample_data  = 12'h0;
        repeat (3) @(negedge clk);
        chk("rst_drdy0", {31'h0, drdy0}, 32'd0);
        chk("rst_do0", {16'h0, do0}, 32'd0);
        chk("rst_perr0", {31'h0, perr0}, 32'd0);
        chk("rst_drdy1", {31'h0, drdy1}, 32'd0);
        chk("rst_perr1", {31'h0, perr1}, 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Measurement read
        sample(6'h10, 12'hABC);
        txn(0, 0, 7'h10, 16'h0, 16'hABC0);
        txn(0, 0, 7'h3F, 16'h0, 16'h0000);

        // Config write, then read in the cycle after its drdy
        txn(0, 1, 7'h41, 16'h1234, 16'h0000);
        txn(0, 0, 7'h41, 16'h0, 16'h1234);

        // Config space edges
        txn(0, 1, 7'h7F, 16'hA5A5, 16'h0000);
        txn(0, 1, 7'h40, 16'h5A5A, 16'h0000);
        txn(0, 0, 7'h7F, 16'h0, 16'hA5A5);
        txn(0, 0, 7'h40, 16'h0, 16'h5A5A);

        // Write to read-only space is acknowledged but dropped
        sample(6'h05, 12'h0FF);
        txn(0, 1, 7'h05, 16'hFFFF, 16'h0000);
        txn(0, 0, 7'h05, 16'h0, 16'h0FF0);
        chk("ro_perr", {31'h0, perr0}, 32'd0);

        // Sample and read accept collide on the same address
        sample(6'h03, 12'h002);
        sample_valid = 1'b1;
        sample_chan  = 6'h03;
        sample_data  = 12'h001;
        issue(0, 0, 7'h03, 16'h0, 16'h0020);
        sample_valid = 1'b0;
        repeat (4) @(negedge clk);
        txn(0, 0, 7'h03, 16'h0, 16'h0010);

        // Second den two cycles into a transaction
        chk("pe_init", {31'h0, perr0}, 32'd0);
        issue(0, 0, 7'h41, 16'h0, 16'h1234);
        @(negedge clk);
        chk("pe_before", {31'h0, perr0}, 32'd0);
        dwe   = 1'b1;
        daddr = 7'h40;
        di    = 16'hFFFF;
        den   = 1'b1;
        @(negedge clk);
        den   = 1'b0;
        dwe   = 1'b0;
        @(negedge clk);
        chk("pe_set", {31'h0, perr0}, 32'd1);
        repeat (3) @(negedge clk);
        chk("pe_sticky", {31'h0, perr0}, 32'd1);
        txn(0, 0, 7'h40, 16'h0, 16'h5A5A);
        chk("pe_still", {31'h0, perr0}, 32'd1);

        // LATENCY = 1 instance
        txn(1, 1, 7'h60, 16'h5A5A, 16'h0000);
        txn(1, 0, 7'h60, 16'h0, 16'h5A5A);
        chk("l1_perr", {31'h0, perr1}, 32'd0);

        // Reset one cycle after a write accept
        dwe   = 1'b1;
        daddr = 7'h50;
        di    = 16'hBEEF;
        den   = 1'b1;
        @(negedge clk);
        den   = 1'b0;
        dwe   = 1'b0;
        rst   = 1'b1;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        chk("abort_perr", {31'h0, perr0}, 32'd0);
        repeat (4) @(negedge clk);
        txn(0, 0, 7'h50, 16'h0, 16'h0000);
        txn(0, 0, 7'h41, 16'h0, 16'h0000);
        txn(0, 0, 7'h10, 16'h0, 16'h0000);

        repeat (6) @(negedge clk);
        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
